// File: rtl/ccip_mmio_pkg.sv
// Shared types and constants for the CCI-P MMIO responder.
package ccip_mmio_pkg;

  // MMIO request length encoding as carried in the C0Rx MMIO header
  typedef enum logic [1:0] {
    eMMIO_LEN_4B   = 2'b00,
    eMMIO_LEN_8B   = 2'b01,
    eMMIO_LEN_64B  = 2'b10,
    eMMIO_LEN_RSVD = 2'b11
  } t_mmio_len;

  // Fixed CSR indices; everything from CSR_FIRST_RW upward is host-writable
  localparam int CSR_DFH      = 0;
  localparam int CSR_AFU_ID_L = 1;
  localparam int CSR_AFU_ID_H = 2;
  localparam int CSR_FIRST_RW = 3;

  // One slot of the read response pipeline
  typedef struct packed {
    logic        valid;
    logic [8:0]  tid;
    logic [63:0] word;
    t_mmio_len   len;
    logic        hi_dw;
    logic        err;
  } t_mmio_rd_stage;

  // A request shape the responder cannot serve: 64B, reserved, or an 8B access
  // that is not QW aligned. Address range is checked separately.
  function automatic logic mmio_fmt_err(input t_mmio_len len, input logic hi_dw);
    case (len)
      eMMIO_LEN_4B: return 1'b0;
      eMMIO_LEN_8B: return hi_dw;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ccip_mmio_csr_file.sv
// CSR storage: read-only header words, RW registers, write decode,
// per-CSR write strobes and a combinational read port.
module ccip_mmio_csr_file
  import ccip_mmio_pkg::*;
#(
  parameter int             NUM_CSR   = 16,
  parameter logic [63:0]    DFH_VALUE = 64'h1000_0000_0000_0000,
  parameter logic [127:0]   AFU_ID    = 128'h0,
  localparam int            IW        = $clog2(NUM_CSR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [IW-1:0]          wr_idx,
  input  t_mmio_len              wr_len,
  input  logic                   wr_hi_dw,
  input  logic                   wr_oor,
  input  logic [63:0]            wr_data,
  input  logic [IW-1:0]          rd_idx,
  output logic [63:0]            rd_word,
  output logic                   wr_err,
  output logic [NUM_CSR*64-1:0]  csr_q,
  output logic [NUM_CSR-1:0]     wr_strobe
);

  logic [63:0]        csr_word [NUM_CSR];
  logic               wr_commit;
  logic [NUM_CSR-1:0] strobe_reg;

  // Malformed or out-of-range writes are errors; legal writes that land on a
  // read-only word are dropped without complaint.
  assign wr_err    = wr_valid & (wr_oor | mmio_fmt_err(wr_len, wr_hi_dw));
  assign wr_commit = wr_valid & ~wr_err & (wr_idx >= IW'(CSR_FIRST_RW));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CSR; gi++) begin : g_csr
      if (gi == CSR_DFH) begin : g_dfh
        assign csr_word[gi] = DFH_VALUE;
      end else if (gi == CSR_AFU_ID_L) begin : g_id_l
        assign csr_word[gi] = AFU_ID[63:0];
      end else if (gi == CSR_AFU_ID_H) begin : g_id_h
        assign csr_word[gi] = AFU_ID[127:64];
      end else begin : g_rw
        logic [63:0] csr_reg;
        // Commit a legal write to this CSR: full QW or one DW half
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            csr_reg <= '0;
          end else if (wr_commit && (wr_idx == IW'(gi))) begin
            if (wr_len == eMMIO_LEN_8B) begin
              csr_reg <= wr_data;
            end else if (wr_hi_dw) begin
              csr_reg[63:32] <= wr_data[31:0];
            end else begin
              csr_reg[31:0] <= wr_data[31:0];
            end
          end
        end
        assign csr_word[gi] = csr_reg;
      end
      assign csr_q[64*gi +: 64] = csr_word[gi];
    end
  endgenerate

  // One-cycle strobe for the CSR that was just written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_reg <= '0;
    end else begin
      strobe_reg <= wr_commit ? (NUM_CSR'(1) << wr_idx) : '0;
    end
  end

  assign wr_strobe = strobe_reg;
  assign rd_word   = csr_word[rd_idx];

endmodule

// File: rtl/ccip_mmio_responder.sv
// AFU-side CCI-P MMIO target: decodes C0Rx MMIO requests, hosts the CSR file
// and answers every read on C2Tx exactly two cycles after it arrived.
module ccip_mmio_responder
  import ccip_mmio_pkg::*;
#(
  parameter int           NUM_CSR   = 16,
  parameter logic [63:0]  DFH_VALUE = 64'h1000_0000_0000_0000,
  parameter logic [127:0] AFU_ID    = 128'h0
) (
  input  logic                   clk,
  input  logic                   SoftReset_n,
  input  logic                   mmio_wr_valid,
  input  logic                   mmio_rd_valid,
  input  logic [15:0]            mmio_address,
  input  logic [1:0]             mmio_length,
  input  logic [8:0]             mmio_tid,
  input  logic [63:0]            mmio_wr_data,
  output logic                   mmio_rd_rsp_valid,
  output logic [8:0]             mmio_rd_rsp_tid,
  output logic [63:0]            mmio_rd_rsp_data,
  output logic [NUM_CSR*64-1:0]  csr_q,
  output logic [NUM_CSR-1:0]     csr_wr_strobe,
  output logic                   mmio_err
);

  localparam int IW = $clog2(NUM_CSR);

  logic [IW-1:0]  req_idx;
  logic           req_oor;
  t_mmio_len      req_len;
  logic           rd_err;
  logic           wr_err;
  logic [63:0]    rd_word;
  t_mmio_rd_stage s1_next;
  t_mmio_rd_stage s1_reg;
  logic           err_reg;
  logic           rsp_valid_reg;
  logic [8:0]     rsp_tid_reg;
  logic [63:0]    rsp_data_reg;

  // Address is in DW units: bit 0 picks the DW half, the next IW bits pick the CSR
  assign req_idx = mmio_address[IW:1];
  assign req_oor = |mmio_address[15:IW+1];
  assign req_len = t_mmio_len'(mmio_length);
  assign rd_err  = req_oor | mmio_fmt_err(req_len, mmio_address[0]);

  ccip_mmio_csr_file #(
    .NUM_CSR   (NUM_CSR),
    .DFH_VALUE (DFH_VALUE),
    .AFU_ID    (AFU_ID)
  ) u_csr_file (
    .clk       (clk),
    .rst_n     (SoftReset_n),
    .wr_valid  (mmio_wr_valid),
    .wr_idx    (req_idx),
    .wr_len    (req_len),
    .wr_hi_dw  (mmio_address[0]),
    .wr_oor    (req_oor),
    .wr_data   (mmio_wr_data),
    .rd_idx    (req_idx),
    .rd_word   (rd_word),
    .wr_err    (wr_err),
    .csr_q     (csr_q),
    .wr_strobe (csr_wr_strobe)
  );

  // Capture the read header and the pre-write CSR word for stage 1
  always_comb begin
    s1_next       = '0;
    s1_next.valid = mmio_rd_valid;
    s1_next.tid   = mmio_tid;
    s1_next.word  = rd_word;
    s1_next.len   = req_len;
    s1_next.hi_dw = mmio_address[0];
    s1_next.err   = rd_err;
  end

  // Stage 1 register plus the error pulse (bad write, bad read, or both valids at once)
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      s1_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      s1_reg  <= s1_next;
      err_reg <= wr_err | (mmio_rd_valid & rd_err) | (mmio_wr_valid & mmio_rd_valid);
    end
  end

  // Stage 2: shape the response; bad reads are still answered, with zero data
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_tid_reg   <= '0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= s1_reg.valid;
      rsp_tid_reg   <= s1_reg.valid ? s1_reg.tid : '0;
      if (!s1_reg.valid || s1_reg.err) begin
        rsp_data_reg <= '0;
      end else if (s1_reg.len == eMMIO_LEN_8B) begin
        rsp_data_reg <= s1_reg.word;
      end else if (s1_reg.hi_dw) begin
        rsp_data_reg <= {32'h0, s1_reg.word[63:32]};
      end else begin
        rsp_data_reg <= {32'h0, s1_reg.word[31:0]};
      end
    end
  end

  assign mmio_rd_rsp_valid = rsp_valid_reg;
  assign mmio_rd_rsp_tid   = rsp_tid_reg;
  assign mmio_rd_rsp_data  = rsp_data_reg;
  assign mmio_err          = err_reg;

endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Directed and randomized checks of the MMIO responder against a CSR-array model.
module tb_ccip_mmio_responder;

  localparam int           NUM_CSR = 16;
  localparam logic [63:0]  DFH_V   = 64'h1000_0000_0000_0000;
  localparam logic [127:0] AFU_V   = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;

  logic                  clk = 1'b0;
  logic                  SoftReset_n = 1'b0;
  logic                  mmio_wr_valid = 1'b0;
  logic                  mmio_rd_valid = 1'b0;
  logic [15:0]           mmio_address = '0;
  logic [1:0]            mmio_length = '0;
  logic [8:0]            mmio_tid = '0;
  logic [63:0]           mmio_wr_data = '0;
  logic                  mmio_rd_rsp_valid;
  logic [8:0]            mmio_rd_rsp_tid;
  logic [63:0]           mmio_rd_rsp_data;
  logic [NUM_CSR*64-1:0] csr_q;
  logic [NUM_CSR-1:0]    csr_wr_strobe;
  logic                  mmio_err;

  ccip_mmio_responder #(
    .NUM_CSR   (NUM_CSR),
    .DFH_VALUE (DFH_V),
    .AFU_ID    (AFU_V)
  ) dut (
    .clk               (clk),
    .SoftReset_n       (SoftReset_n),
    .mmio_wr_valid     (mmio_wr_valid),
    .mmio_rd_valid     (mmio_rd_valid),
    .mmio_address      (mmio_address),
    .mmio_length       (mmio_length),
    .mmio_tid          (mmio_tid),
    .mmio_wr_data      (mmio_wr_data),
    .mmio_rd_rsp_valid (mmio_rd_rsp_valid),
    .mmio_rd_rsp_tid   (mmio_rd_rsp_tid),
    .mmio_rd_rsp_data  (mmio_rd_rsp_data),
    .csr_q             (csr_q),
    .csr_wr_strobe     (csr_wr_strobe),
    .mmio_err          (mmio_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [8:0]  tid;
    logic [63:0] data;
  } exp_rsp_t;

  exp_rsp_t    rspq[$];
  logic [63:0] m [NUM_CSR];
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  int          proto_violations = 0;

  // Simultaneous write and read is a host protocol violation; the bench injects it on purpose
  always @(posedge clk) begin
    if (SoftReset_n && mmio_wr_valid && mmio_rd_valid) begin
      proto_violations++;
      $display("note: simultaneous MMIO write and read at %0t (protocol violation)", $time);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CSR; i++) m[i] = 64'h0;
    m[0] = DFH_V;
    m[1] = AFU_V[63:0];
    m[2] = AFU_V[127:64];
    rspq.delete();
    rspq.push_back('{v: 1'b0, tid: 9'h0, data: 64'h0});
  endtask

  task automatic check_csrs(input string tag);
    for (int i = 0; i < NUM_CSR; i++) chk($sformatf("%s_csr%0d", tag, i), csr_q[64*i +: 64], m[i]);
  endtask

  // One bus cycle: drive a request, predict its effects, clock, then check
  task automatic do_cycle(input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
    int          idx;
    logic        bad;
    logic        commit;
    logic        exp_err;
    logic [15:0] exp_strobe;
    exp_rsp_t    e;
    exp_rsp_t    got;
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_address  = addr;
    mmio_length   = len;
    mmio_tid      = tid;
    mmio_wr_data  = data;
    idx = int'(addr[4:1]);
    bad = (addr[15:5] != 0) || (len >= 2'd2) || (len == 2'd1 && addr[0]);
    // read sees the CSR as it was before any same-cycle write
    e.v = rd;
    e.tid = rd ? tid : 9'h0;
    if (!rd || bad)      e.data = 64'h0;
    else if (len == 2'd1) e.data = m[idx];
    else if (addr[0])    e.data = {32'h0, m[idx][63:32]};
    else                 e.data = {32'h0, m[idx][31:0]};
    rspq.push_back(e);
    exp_err    = (wr && bad) || (rd && bad) || (wr && rd);
    commit     = wr && !bad && idx >= 3;
    exp_strobe = commit ? (16'h1 << idx) : 16'h0;
    if (commit) begin
      if (len == 2'd1)  m[idx] = data;
      else if (addr[0]) m[idx][63:32] = data[31:0];
      else              m[idx][31:0] = data[31:0];
    end
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    got = rspq.pop_front();
    chk("rsp_valid", {63'h0, mmio_rd_rsp_valid}, {63'h0, got.v});
    if (got.v) begin
      chk("rsp_tid_known", {63'h0, $isunknown(mmio_rd_rsp_tid)}, 64'h0);
      chk("rsp_tid", {55'h0, mmio_rd_rsp_tid}, {55'h0, got.tid});
      chk("rsp_data", mmio_rd_rsp_data, got.data);
    end
    chk("mmio_err", {63'h0, mmio_err}, {63'h0, exp_err});
    chk("wr_strobe", {48'h0, csr_wr_strobe}, {48'h0, exp_strobe});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 16'h0, 2'b00, 9'h0, 64'h0);
  endtask

  initial begin
    logic [15:0] raddr;
    logic [1:0]  rlen;
    int          op;
    int          lsel;

    // Reset state
    SoftReset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {63'h0, mmio_rd_rsp_valid}, 64'h0);
    chk("reset_rsp_data", mmio_rd_rsp_data, 64'h0);
    chk("reset_err", {63'h0, mmio_err}, 64'h0);
    chk("reset_strobe", {48'h0, csr_wr_strobe}, 64'h0);
    check_csrs("reset");
    SoftReset_n = 1'b1;

    // 1: 8B write then 8B read of CSR3
    do_cycle(1'b1, 1'b0, 16'h0006, 2'b01, 9'h000, 64'hDEAD_BEEF_0123_4567);
    do_cycle(1'b0, 1'b1, 16'h0006, 2'b01, 9'h1A5, 64'h0);
    idle(2);

    // 2: 4B upper-half write, then back-to-back 4B reads of both halves
    do_cycle(1'b1, 1'b0, 16'h0009, 2'b00, 9'h000, 64'h0000_0000_CAFE_F00D);
    do_cycle(1'b0, 1'b1, 16'h0008, 2'b00, 9'h011, 64'h0);
    do_cycle(1'b0, 1'b1, 16'h0009, 2'b00, 9'h012, 64'h0);
    idle(2);

    // 3: read AFU_ID low, write to DFH is silently ignored
    do_cycle(1'b0, 1'b1, 16'h0002, 2'b01, 9'h033, 64'h0);
    do_cycle(1'b1, 1'b0, 16'h0000, 2'b01, 9'h000, 64'h5555_AAAA_5555_AAAA);
    idle(2);
    check_csrs("ro_write");

    // 4: misaligned 8B, 64B and out-of-range reads are answered with zero data
    do_cycle(1'b0, 1'b1, 16'h0003, 2'b01, 9'h041, 64'h0);
    do_cycle(1'b0, 1'b1, 16'h0004, 2'b10, 9'h042, 64'h0);
    do_cycle(1'b0, 1'b1, 16'h0100, 2'b01, 9'h043, 64'h0);
    idle(2);

    // 6: write and read of CSR5 in the same cycle returns the old value
    do_cycle(1'b1, 1'b0, 16'h000A, 2'b01, 9'h000, 64'h1111_2222_3333_4444);
    do_cycle(1'b1, 1'b1, 16'h000A, 2'b01, 9'h061, 64'h9999_8888_7777_6666);
    do_cycle(1'b0, 1'b1, 16'h000A, 2'b01, 9'h062, 64'h0);
    idle(2);

    // 5: reset lands while a read is in flight
    do_cycle(1'b0, 1'b1, 16'h0006, 2'b01, 9'h0AB, 64'h0);
    SoftReset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid_a", {63'h0, mmio_rd_rsp_valid}, 64'h0);
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid_b", {63'h0, mmio_rd_rsp_valid}, 64'h0);
    model_reset();
    check_csrs("midrst");
    SoftReset_n = 1'b1;
    idle(1);
    do_cycle(1'b0, 1'b1, 16'h0006, 2'b01, 9'h0B1, 64'h0);
    do_cycle(1'b0, 1'b1, 16'h000A, 2'b01, 9'h0B2, 64'h0);
    idle(2);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      raddr = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) raddr = raddr | (16'($urandom_range(1, 2047)) << 5);
      lsel = $urandom_range(0, 9);
      rlen = (lsel < 4) ? 2'b00 : (lsel < 8) ? 2'b01 : (lsel == 8) ? 2'b10 : 2'b11;
      op = $urandom_range(0, 9);
      do_cycle(op >= 2 && op <= 5 || op == 9, op >= 6, raddr, rlen,
               9'($urandom_range(0, 511)), {$urandom, $urandom});
    end
    idle(2);
    check_csrs("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
